// File: rtl/uart_ocp_pkg.sv
// -----------------------------------------------------------------------------
// uart_ocp_pkg
// Shared encodings for the UART-to-OCP bridge master:
//   - OCP MCmd and SResp encodings
//   - status characters returned over the UART link ('K', 'E', 'T')
//   - FSM state enumeration (also exported on fsm_state for debug)
// -----------------------------------------------------------------------------
package uart_ocp_pkg;

    typedef enum logic [2:0] {
        OCP_CMD_IDLE = 3'b000,
        OCP_CMD_WR   = 3'b001,
        OCP_CMD_RD   = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        OCP_RESP_NULL = 2'b00,
        OCP_RESP_DVA  = 2'b01,
        OCP_RESP_FAIL = 2'b10,
        OCP_RESP_ERR  = 2'b11
    } ocp_resp_e;

    localparam logic [7:0] STAT_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] STAT_ERR = 8'h45;  // 'E'
    localparam logic [7:0] STAT_TMO = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_CMD       = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_SEND_STAT = 3'd5,
        ST_SEND_DATA = 3'd6
    } state_e;

endpackage

// File: rtl/uart_ocp_master_if.sv
// -----------------------------------------------------------------------------
// uart_ocp_master_if
// Bundles the UART byte stream (rx/tx) and the OCP master bus of the
// UART-to-OCP bridge.
//   master modport : the bridge (uart_ocp_master)
//   slave modport  : the environment (UART + OCP slave side)
// Signals:
//   rx_valid/rx_data        received UART byte strobe
//   tx_valid/tx_data/tx_ready  byte to the UART transmitter (valid/ready)
//   MCmd/MAddr/MData/SCmdAccept  OCP request phase
//   SResp/SData/MRespAccept      OCP response phase
// -----------------------------------------------------------------------------
interface uart_ocp_master_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [2:0] MCmd;
    logic [7:0] MAddr;
    logic [7:0] MData;
    logic       SCmdAccept;
    logic [7:0] SData;
    logic [1:0] SResp;
    logic       MRespAccept;

    modport master (
        input  rx_valid, rx_data, tx_ready, SCmdAccept, SData, SResp,
        output tx_valid, tx_data, MCmd, MAddr, MData, MRespAccept
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, SCmdAccept, SData, SResp,
        input  tx_valid, tx_data, MCmd, MAddr, MData, MRespAccept
    );
endinterface

// File: rtl/uart_ocp_master.sv
// -----------------------------------------------------------------------------
// uart_ocp_master
// Turns UART command frames into single OCP transactions and returns a status
// byte (and read data) over the UART transmitter.
//   Write frame: WR_CHAR, addr, data   -> reply 'K' / 'E' / 'T'
//   Read  frame: RD_CHAR, addr         -> reply 'K' + data, or 'E' / 'T'
// Ports:
//   clk        link clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        uart_ocp_master_if.master (UART rx/tx + OCP master signals)
//   overrun    sticky flag: byte received while the bridge was busy
//   fsm_state  current state encoding (debug)
// Configuration:
//   UART_OCP_TIMEOUT_EN  when defined, WAIT_RESP gives up after TMO_CYC
//                        cycles and answers 'T'; otherwise it waits forever.
// -----------------------------------------------------------------------------
module uart_ocp_master
    import uart_ocp_pkg::*;
#(
    parameter logic [7:0] WR_CHAR = 8'h57,
    parameter logic [7:0] RD_CHAR = 8'h52,
    parameter int         TMO_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_ocp_master_if.master         bus,
    output logic                      overrun,
    output logic [2:0]                fsm_state
);

    state_e     state_reg;
    ocp_cmd_e   op_reg;        // operation latched from the command byte
    ocp_cmd_e   mcmd_reg;
    logic [7:0] maddr_reg;
    logic [7:0] mdata_reg;
    logic       mresp_accept_reg;
    logic       tx_valid_reg;
    logic [7:0] tx_data_reg;
    logic [7:0] sdata_reg;     // read data held for the second reply byte
    logic       dva_reg;       // response was DVA (read data follows status)
    logic       overrun_reg;

`ifdef UART_OCP_TIMEOUT_EN
    // The response deadline is the edge at which the counter would reach
    // TMO_CYC, so SEND_STAT starts exactly TMO_CYC cycles after entry.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
    logic [7:0] tmo_cnt_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            op_reg           <= OCP_CMD_IDLE;
            mcmd_reg         <= OCP_CMD_IDLE;
            maddr_reg        <= 8'h00;
            mdata_reg        <= 8'h00;
            mresp_accept_reg <= 1'b0;
            tx_valid_reg     <= 1'b0;
            tx_data_reg      <= 8'h00;
            sdata_reg        <= 8'h00;
            dva_reg          <= 1'b0;
            overrun_reg      <= 1'b0;
`ifdef UART_OCP_TIMEOUT_EN
            tmo_cnt_reg      <= 8'h00;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        // Anything other than a command byte is silently dropped.
                        if (bus.rx_data == WR_CHAR) begin
                            op_reg    <= OCP_CMD_WR;
                            state_reg <= ST_GET_ADDR;
                        end else if (bus.rx_data == RD_CHAR) begin
                            op_reg    <= OCP_CMD_RD;
                            state_reg <= ST_GET_ADDR;
                        end
                    end
                end

                ST_GET_ADDR: begin
                    if (bus.rx_valid) begin
                        maddr_reg <= bus.rx_data;
                        if (op_reg == OCP_CMD_WR) begin
                            state_reg <= ST_GET_DATA;
                        end else begin
                            // Command is registered here so it is on the bus
                            // in the very first CMD cycle.
                            mcmd_reg  <= OCP_CMD_RD;
                            state_reg <= ST_CMD;
                        end
                    end
                end

                ST_GET_DATA: begin
                    if (bus.rx_valid) begin
                        mdata_reg <= bus.rx_data;
                        mcmd_reg  <= OCP_CMD_WR;
                        state_reg <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (bus.rx_valid) overrun_reg <= 1'b1;
                    if (bus.SCmdAccept) begin
                        mcmd_reg         <= OCP_CMD_IDLE;
                        mresp_accept_reg <= 1'b1;
                        state_reg        <= ST_WAIT_RESP;
`ifdef UART_OCP_TIMEOUT_EN
                        tmo_cnt_reg      <= 8'h00;
`endif
                    end
                end

                ST_WAIT_RESP: begin
                    if (bus.rx_valid) overrun_reg <= 1'b1;
                    // A response always takes priority over the deadline.
                    if (ocp_resp_e'(bus.SResp) != OCP_RESP_NULL) begin
                        sdata_reg        <= bus.SData;
                        dva_reg          <= (ocp_resp_e'(bus.SResp) == OCP_RESP_DVA);
                        tx_data_reg      <= (ocp_resp_e'(bus.SResp) == OCP_RESP_DVA)
                                            ? STAT_OK : STAT_ERR;
                        tx_valid_reg     <= 1'b1;
                        mresp_accept_reg <= 1'b0;
                        state_reg        <= ST_SEND_STAT;
                    end
`ifdef UART_OCP_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LAST) begin
                        tmo_cnt_reg      <= tmo_cnt_reg + 8'd1;
                        dva_reg          <= 1'b0;
                        tx_data_reg      <= STAT_TMO;
                        tx_valid_reg     <= 1'b1;
                        mresp_accept_reg <= 1'b0;
                        state_reg        <= ST_SEND_STAT;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
`endif
                end

                ST_SEND_STAT: begin
                    if (bus.rx_valid) overrun_reg <= 1'b1;
                    if (bus.tx_ready) begin
                        if (op_reg == OCP_CMD_RD && dva_reg) begin
                            tx_data_reg <= sdata_reg;
                            state_reg   <= ST_SEND_DATA;
                        end else begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end
                    end
                end

                ST_SEND_DATA: begin
                    if (bus.rx_valid) overrun_reg <= 1'b1;
                    if (bus.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg        <= ST_IDLE;
                    mcmd_reg         <= OCP_CMD_IDLE;
                    mresp_accept_reg <= 1'b0;
                    tx_valid_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MCmd        = mcmd_reg;
    assign bus.MAddr       = maddr_reg;
    assign bus.MData       = mdata_reg;
    assign bus.MRespAccept = mresp_accept_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign bus.tx_data     = tx_data_reg;
    assign overrun         = overrun_reg;
    assign fsm_state       = state_reg;

endmodule

// File: tb/tb_uart_ocp_master.sv
// -----------------------------------------------------------------------------
// tb_uart_ocp_master
// Directed self-checking bench for uart_ocp_master. Inputs change 1 ns after
// the rising edge; outputs are checked at that same point, away from the edge.
// Works with and without UART_OCP_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_uart_ocp_master;
    localparam int TMO_CYC = 255;

    logic       clk;
    logic       rst_n;
    logic       overrun;
    logic [2:0] fsm_state;

    int errors = 0;
    int checks = 0;

    uart_ocp_master_if bus ();

    uart_ocp_master #(
        .WR_CHAR (8'h57),
        .RD_CHAR (8'h52),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic accept_cmd();
        bus.SCmdAccept = 1'b1;
        tick();
        bus.SCmdAccept = 1'b0;
    endtask

    task automatic respond(input logic [1:0] resp, input logic [7:0] data);
        bus.SResp = resp;
        bus.SData = data;
        tick();
        bus.SResp = 2'b00;
        bus.SData = 8'h00;
    endtask

    task automatic take_tx();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;

        rst_n          = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.tx_ready   = 1'b0;
        bus.SCmdAccept = 1'b0;
        bus.SData      = 8'h00;
        bus.SResp      = 2'b00;

        // Reset state
        tick();
        check("rst_state", fsm_state, 3'd0);
        check("rst_mcmd", bus.MCmd, 3'b000);
        check("rst_maddr", bus.MAddr, 8'h00);
        check("rst_txv", bus.tx_valid, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        tick();

        // Write: 57,45,A5, accept after 2 cycles, DVA -> 'K'
        send_byte(8'h57);
        send_byte(8'h45);
        send_byte(8'hA5);
        check("wr_mcmd_first", bus.MCmd, 3'b001);
        check("wr_maddr", bus.MAddr, 8'h45);
        check("wr_mdata", bus.MData, 8'hA5);
        check("wr_mra_cmd", bus.MRespAccept, 1'b0);
        tick();
        tick();
        check("wr_mcmd_held", bus.MCmd, 3'b001);
        accept_cmd();
        check("wr_mcmd_idle", bus.MCmd, 3'b000);
        check("wr_state_wait", fsm_state, 3'd4);
        check("wr_mra", bus.MRespAccept, 1'b1);
        respond(2'b01, 8'h00);
        check("wr_txv", bus.tx_valid, 1'b1);
        check("wr_txd", bus.tx_data, 8'h4B);
        check("wr_mra_off", bus.MRespAccept, 1'b0);
        take_tx();
        check("wr_txv_done", bus.tx_valid, 1'b0);
        check("wr_state_idle", fsm_state, 3'd0);

        // Read: 52,C3, DVA SData=3C -> 'K', 3 stall cycles, 3C
        send_byte(8'h52);
        send_byte(8'hC3);
        check("rd_mcmd", bus.MCmd, 3'b010);
        check("rd_maddr", bus.MAddr, 8'hC3);
        accept_cmd();
        respond(2'b01, 8'h3C);
        check("rd_txd_stat", bus.tx_data, 8'h4B);
        take_tx();
        for (int i = 0; i < 3; i++) begin
            check("rd_txv_stall", bus.tx_valid, 1'b1);
            check("rd_txd_stall", bus.tx_data, 8'h3C);
            tick();
        end
        check("rd_state_data", fsm_state, 3'd6);
        take_tx();
        check("rd_txv_done", bus.tx_valid, 1'b0);

        // Junk byte then read with ERR -> single 'E'
        send_byte(8'h11);
        check("junk_dropped", fsm_state, 3'd0);
        send_byte(8'h52);
        send_byte(8'h00);
        check("err_mcmd", bus.MCmd, 3'b010);
        accept_cmd();
        respond(2'b11, 8'hFF);
        check("err_txd", bus.tx_data, 8'h45);
        take_tx();
        check("err_txv_done", bus.tx_valid, 1'b0);
        check("err_state_idle", fsm_state, 3'd0);

        // Overrun during WAIT_RESP; transaction still completes
        send_byte(8'h52);
        send_byte(8'h10);
        accept_cmd();
        send_byte(8'h99);
        check("ovr_set", overrun, 1'b1);
        check("ovr_state", fsm_state, 3'd4);
        respond(2'b01, 8'h77);
        check("ovr_txd_stat", bus.tx_data, 8'h4B);
        take_tx();
        check("ovr_txd_data", bus.tx_data, 8'h77);
        take_tx();
        check("ovr_sticky", overrun, 1'b1);

        // Response in the last timeout cycle beats the timeout
        send_byte(8'h52);
        send_byte(8'h20);
        accept_cmd();
        for (int i = 0; i < TMO_CYC - 1; i++) tick();
        respond(2'b01, 8'h5A);
        check("race_txd", bus.tx_data, 8'h4B);
        take_tx();
        check("race_txd_data", bus.tx_data, 8'h5A);
        take_tx();

        // No response at all
        send_byte(8'h52);
        send_byte(8'h08);
        accept_cmd();
        n = 0;
        seen = 0;
        while (n < 400) begin
            tick();
            n++;
            if (bus.tx_valid) begin
                seen = 1;
                break;
            end
        end
`ifdef UART_OCP_TIMEOUT_EN
        check("tmo_seen", seen, 1);
        check("tmo_cycles", n, TMO_CYC);
        check("tmo_txd", bus.tx_data, 8'h54);
        take_tx();
        check("tmo_state_idle", fsm_state, 3'd0);
`else
        check("notmo_no_tx", seen, 0);
        check("notmo_waiting", fsm_state, 3'd4);
`endif

        // Async reset during CMD
        rst_n = 1'b0;
        #2;
        check("rst_ovr_clr", overrun, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h30);
        check("arst_mcmd_pre", bus.MCmd, 3'b001);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst_mcmd", bus.MCmd, 3'b000);
        check("arst_state", fsm_state, 3'd0);
        check("arst_maddr", bus.MAddr, 8'h00);
        tick();
        rst_n = 1'b1;
        bus.SCmdAccept = 1'b1;
        bus.SResp      = 2'b01;
        bus.tx_ready   = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tx_valid) seen = 1;
        end
        bus.SCmdAccept = 1'b0;
        bus.SResp      = 2'b00;
        bus.tx_ready   = 1'b0;
        check("arst_no_tx", seen, 0);
        check("arst_idle", fsm_state, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_ocp_master.md
UART_OCP_MASTER -- requirements
Module: uart_ocp_master

Interface
REQ-001 Parameters SHALL be: WR_CHAR, 8'h57, write command byte; RD_CHAR, 8'h52, read command byte; TMO_CYC, 255, response timeout in clk cycles.
REQ-002 clk  input  1  50 MHz link clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_valid  input  1  one-cycle strobe, received UART byte valid.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 tx_valid  output  1  byte for UART transmitter valid; held until tx_ready.
REQ-007 tx_data  output  8  byte to transmit; stable while tx_valid=1.
REQ-008 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-009 MCmd  output  3  command: 000 IDLE, 001 WR, 010 RD.
REQ-010 MAddr  output  8  target address (bits 7:6 select slave in downstream router).
REQ-011 MData  output  8  write data.
REQ-012 SCmdAccept  input  1  command accepted.
REQ-013 SData  input  8  read data.
REQ-014 SResp  input  2  00 NULL, 01 DVA, 10 FAIL, 11 ERR.
REQ-015 MRespAccept  output  1  master accepts response.
REQ-016 overrun  output  1  sticky: rx byte arrived while not accepting bytes.
REQ-017 fsm_state  output  3  current state encoding, debug monitor.

Function
REQ-018 States SHALL be IDLE, GET_ADDR, GET_DATA, CMD, WAIT_RESP, SEND_STAT, SEND_DATA.
REQ-019 IDLE: rx_valid with rx_data=WR_CHAR or RD_CHAR -> GET_ADDR, latch op; any other byte SHALL be silently dropped.
REQ-020 GET_ADDR: rx_valid -> latch MAddr; WR -> GET_DATA, RD -> CMD.
REQ-021 GET_DATA: rx_valid -> latch MData, -> CMD.
REQ-022 CMD: MCmd=WR/RD driven from the first CMD cycle, i.e. one cycle after the last frame byte strobe; MAddr/MData stable; held until SCmdAccept=1, then -> WAIT_RESP with MCmd=IDLE next cycle.
REQ-023 WAIT_RESP: MRespAccept=1 (0 in all other states); SResp!=NULL sampled -> capture SResp/SData, -> SEND_STAT.
REQ-024 SEND_STAT: tx_data=8'h4B ('K') for DVA, 8'h45 ('E') for FAIL/ERR, 8'h54 ('T') for timeout; on tx_ready: RD with DVA -> SEND_DATA, else -> IDLE.
REQ-025 SEND_DATA: tx_data=captured SData; on tx_ready -> IDLE.
REQ-026 tx_valid SHALL be 1 exactly in SEND_STAT/SEND_DATA; tx_valid & tx_ready in the same cycle completes the byte.
REQ-027 rx_valid in CMD, WAIT_RESP, SEND_STAT or SEND_DATA SHALL drop the byte and set overrun.
REQ-028 SCmdAccept and SResp SHALL be ignored outside CMD and WAIT_RESP respectively.
REQ-029 No inter-byte timeout; a partial frame waits indefinitely.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, MCmd=000, MAddr=0, MData=0, MRespAccept=0, tx_valid=0, tx_data=0, overrun=0, timeout counter=0.
REQ-031 Reset mid-transaction SHALL abandon it with no response byte after release.

Configuration
REQ-032 With UART_OCP_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT_RESP entry and increment each WAIT_RESP cycle; on reaching TMO_CYC with SResp=NULL -> SEND_STAT with 'T'.
REQ-033 A response arriving in the same cycle as the counter reaching TMO_CYC SHALL win over the timeout.
REQ-034 Without UART_OCP_TIMEOUT_EN, no counter exists and WAIT_RESP waits indefinitely.

Structure
REQ-035 Package uart_ocp_pkg SHALL hold MCmd and SResp encodings, status characters 'K'/'E'/'T', and the state enumeration.
REQ-036 The block SHALL be one flat FSM with no sub-module.

Verification
REQ-037 Bytes 57,45,A5; SCmdAccept 2 cycles after MCmd; SResp=DVA -> MCmd=001, MAddr=45, MData=A5; tx byte 4B.
REQ-038 Bytes 52,C3; SResp=DVA with SData=3C -> MCmd=010, MAddr=C3; tx bytes 4B then 3C, with tx_ready low for 3 cycles between.
REQ-039 Byte 11 then 52,00; SResp=ERR -> 11 dropped; single tx byte 45.
REQ-040 With macro, RD frame, no response -> 'T' exactly TMO_CYC cycles after WAIT_RESP entry; without macro -> no tx.
REQ-041 rx byte during WAIT_RESP -> overrun=1 until reset; transaction completes normally.
REQ-042 rst_n low during CMD -> MCmd=000 asynchronously; no tx after release.
